tspi_swap_buffer: RTL and testbench

- Word buffer on the system side of the TSPI host block-swap interface.
- A TX FIFO supplies 32-bit words to the host's write_data_i and advances on the host's signal_next_write_data_o pulse.
- An RX FIFO captures the host's read_data_o on each signal_next_read_data_o pulse.
- The system side (DMA or OBI register front end) fills and drains both FIFOs through valid/ready handshakes; sticky flags report underrun and overrun.

---
 rtl/tspi_swap_buffer.sv | 116 +++++++++++
 tb/tb_tspi_swap_buffer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/tspi_swap_buffer.sv
// System-side word buffer for the TSPI host block-swap interface.
// The TX FIFO feeds the host write path and the RX FIFO captures host read data; sticky flags report underrun and overrun.
module tspi_swap_buffer #(
    parameter int Depth = 8,
    localparam int LvlW = $clog2(Depth) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            clear_err_i,
    input  logic [31:0]     wr_word_i,
    input  logic            wr_valid_i,
    output logic            wr_ready_o,
    output logic [31:0]     rd_word_o,
    output logic            rd_valid_o,
    input  logic            rd_ready_i,
    output logic [31:0]     tspi_write_data_o,
    input  logic            tspi_next_write_i,
    input  logic [31:0]     tspi_read_data_i,
    input  logic            tspi_next_read_i,
    output logic [LvlW-1:0] tx_level_o,
    output logic [LvlW-1:0] rx_level_o,
    output logic            underrun_o,
    output logic            overrun_o
);

    localparam int PtrW = $clog2(Depth);
    localparam logic [LvlW-1:0] FullLvl = LvlW'(Depth);

    logic [31:0]     tx_mem [Depth];
    logic [PtrW-1:0] tx_rd_ptr, tx_wr_ptr;
    logic [LvlW-1:0] tx_level;
    logic            tx_empty, tx_full, tx_push, tx_pop, underrun_ev;

    logic [31:0]     rx_mem [Depth];
    logic [PtrW-1:0] rx_rd_ptr, rx_wr_ptr;
    logic [LvlW-1:0] rx_level;
    logic            rx_empty, rx_full, rx_push, rx_pop, overrun_ev;

    assign tx_empty    = (tx_level == '0);
    assign tx_full     = (tx_level == FullLvl);
    assign tx_push     = wr_valid_i && !tx_full && !flush_i;
    assign tx_pop      = tspi_next_write_i && !tx_empty && !flush_i;
    assign underrun_ev = tspi_next_write_i && tx_empty && !flush_i;

    // A full RX FIFO still accepts a host word when the system drains one in the same cycle.
    assign rx_empty    = (rx_level == '0);
    assign rx_full     = (rx_level == FullLvl);
    assign rx_pop      = rd_ready_i && !rx_empty && !flush_i;
    assign rx_push     = tspi_next_read_i && (!rx_full || rx_pop) && !flush_i;
    assign overrun_ev  = tspi_next_read_i && rx_full && !rx_pop && !flush_i;

    assign wr_ready_o        = !tx_full;
    assign tspi_write_data_o = tx_empty ? 32'h0 : tx_mem[tx_rd_ptr];
    assign rd_valid_o        = !rx_empty;
    assign rd_word_o         = rx_empty ? 32'h0 : rx_mem[rx_rd_ptr];
    assign tx_level_o        = tx_level;
    assign rx_level_o        = rx_level;

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= wr_word_i;
        if (rx_push) rx_mem[rx_wr_ptr] <= tspi_read_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_rd_ptr <= '0;
            tx_wr_ptr <= '0;
            tx_level  <= '0;
        end else if (flush_i) begin
            tx_rd_ptr <= '0;
            tx_wr_ptr <= '0;
            tx_level  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + PtrW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PtrW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_level <= tx_level + LvlW'(1);
                2'b01:   tx_level <= tx_level - LvlW'(1);
                default: tx_level <= tx_level;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_rd_ptr <= '0;
            rx_wr_ptr <= '0;
            rx_level  <= '0;
        end else if (flush_i) begin
            rx_rd_ptr <= '0;
            rx_wr_ptr <= '0;
            rx_level  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + PtrW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PtrW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_level <= rx_level + LvlW'(1);
                2'b01:   rx_level <= rx_level - LvlW'(1);
                default: rx_level <= rx_level;
            endcase
        end
    end

    // A new error event beats a simultaneous clear; flush leaves the flags alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            underrun_o <= 1'b0;
            overrun_o  <= 1'b0;
        end else begin
            underrun_o <= underrun_ev || (underrun_o && !clear_err_i);
            overrun_o  <= overrun_ev  || (overrun_o  && !clear_err_i);
        end
    end

endmodule

// File: tb/tb_tspi_swap_buffer.sv
// Self-checking bench for tspi_swap_buffer: a queue-based model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_tspi_swap_buffer;

    localparam int Depth = 8;
    localparam int LvlW  = $clog2(Depth) + 1;

    logic            clk, rst_n, flush, clear_err;
    logic [31:0]     wr_word, rd_word, write_data, read_data;
    logic            wr_valid, wr_ready, rd_valid, rd_ready;
    logic            next_write, next_read;
    logic [LvlW-1:0] tx_level, rx_level;
    logic            underrun, overrun;

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 0;

    tspi_swap_buffer #(.Depth(Depth)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .clear_err_i(clear_err),
        .wr_word_i(wr_word), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
        .rd_word_o(rd_word), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
        .tspi_write_data_o(write_data), .tspi_next_write_i(next_write),
        .tspi_read_data_i(read_data), .tspi_next_read_i(next_read),
        .tx_level_o(tx_level), .rx_level_o(rx_level),
        .underrun_o(underrun), .overrun_o(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain queues updated from the inputs seen at each rising edge.
    logic [31:0] m_tx[$];
    logic [31:0] m_rx[$];
    bit m_under, m_over;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tx.delete();
            m_rx.delete();
            m_under = 0;
            m_over  = 0;
        end else begin
            bit ev_u, ev_o, rx_take, rx_ok;
            ev_u = 0;
            ev_o = 0;
            if (flush) begin
                m_tx.delete();
                m_rx.delete();
            end else begin
                bit tx_take;
                tx_take = wr_valid && (m_tx.size() < Depth);
                if (next_write) begin
                    if (m_tx.size() > 0) void'(m_tx.pop_front());
                    else ev_u = 1;
                end
                if (tx_take) m_tx.push_back(wr_word);
                rx_take = rd_ready && (m_rx.size() > 0);
                rx_ok   = next_read && ((m_rx.size() < Depth) || rx_take);
                if (next_read && !rx_ok) ev_o = 1;
                if (rx_take) void'(m_rx.pop_front());
                if (rx_ok) m_rx.push_back(read_data);
            end
            m_under = ev_u || (m_under && !clear_err);
            m_over  = ev_o || (m_over && !clear_err);
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check_output("model tx_level", 32'(tx_level), 32'(m_tx.size()));
            check_output("model rx_level", 32'(rx_level), 32'(m_rx.size()));
            check_output("model wr_ready", 32'(wr_ready), 32'(m_tx.size() < Depth));
            check_output("model rd_valid", 32'(rd_valid), 32'(m_rx.size() > 0));
            check_output("model write_data", write_data, (m_tx.size() > 0) ? m_tx[0] : 32'h0);
            check_output("model rd_word", rd_word, (m_rx.size() > 0) ? m_rx[0] : 32'h0);
            check_output("model underrun", 32'(underrun), 32'(m_under));
            check_output("model overrun", 32'(overrun), 32'(m_over));
        end
    end

    task automatic apply_stimulus(input logic wv, input logic [31:0] wd, input logic nw,
                                  input logic nr, input logic [31:0] rdat, input logic rr,
                                  input logic fl, input logic ce);
        wr_valid = wv; wr_word = wd; next_write = nw; next_read = nr;
        read_data = rdat; rd_ready = rr; flush = fl; clear_err = ce;
        @(posedge clk);
        #1;
        wr_valid = 0; wr_word = 0; next_write = 0; next_read = 0;
        read_data = 0; rd_ready = 0; flush = 0; clear_err = 0;
    endtask

    task automatic push_tx(input logic [31:0] d);
        apply_stimulus(1, d, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pop_tx();
        apply_stimulus(0, 0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic push_rx(input logic [31:0] d, input logic rr);
        apply_stimulus(0, 0, 0, 1, d, rr, 0, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 0; flush = 0; clear_err = 0; wr_word = 0; wr_valid = 0;
        rd_ready = 0; next_write = 0; read_data = 0; next_read = 0;
        #2;
        check_output("reset wr_ready", 32'(wr_ready), 32'd1);
        check_output("reset rd_valid", 32'(rd_valid), 32'd0);
        check_output("reset tx_level", 32'(tx_level), 32'd0);
        check_output("reset write_data", write_data, 32'h0);
        check_output("reset flags", {30'd0, underrun, overrun}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1;
        check_en = 1;

        push_tx(32'h11111111);
        push_tx(32'h22222222);
        push_tx(32'h33333333);
        check_output("tx level after 3 pushes", 32'(tx_level), 32'd3);
        check_output("tx head after 3 pushes", write_data, 32'h11111111);
        pop_tx();
        pop_tx();
        check_output("tx head after 2 pops", write_data, 32'h33333333);
        check_output("tx level after 2 pops", 32'(tx_level), 32'd1);

        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < Depth; i++) push_tx(32'h100 + 32'(i));
        check_output("tx full ready", 32'(wr_ready), 32'd0);
        push_tx(32'hDEAD0009);
        check_output("tx 9th push ignored", 32'(tx_level), 32'd8);
        apply_stimulus(1, 32'hBEEF0000, 1, 0, 0, 0, 0, 0);
        check_output("tx push+pop at full level", 32'(tx_level), 32'd7);
        check_output("tx push+pop at full head", write_data, 32'h101);
        for (int i = 0; i < Depth - 1; i++) pop_tx();
        check_output("tx drained level", 32'(tx_level), 32'd0);
        pop_tx();
        check_output("underrun set", 32'(underrun), 32'd1);
        check_output("underrun write_data", write_data, 32'h0);

        for (int i = 0; i < Depth; i++) push_rx(32'hA0 + 32'(i), 0);
        check_output("rx level full", 32'(rx_level), 32'd8);
        push_rx(32'hA8, 0);
        check_output("overrun set", 32'(overrun), 32'd1);
        check_output("rx level after drop", 32'(rx_level), 32'd8);
        push_rx(32'hA9, 1);
        check_output("rx full push+pop level", 32'(rx_level), 32'd8);
        check_output("rx head after push+pop", rd_word, 32'hA1);

        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
        check_output("clear underrun", 32'(underrun), 32'd0);
        check_output("clear overrun", 32'(overrun), 32'd0);
        apply_stimulus(0, 0, 1, 0, 0, 0, 0, 1);
        check_output("set beats clear underrun", 32'(underrun), 32'd1);
        check_output("set beats clear overrun", 32'(overrun), 32'd0);

        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) push_tx(32'h500 + 32'(i));
        for (int i = 0; i < 3; i++) push_rx(32'h300 + 32'(i), 0);
        check_output("pre-flush tx level", 32'(tx_level), 32'd5);
        check_output("pre-flush rx level", 32'(rx_level), 32'd3);
        apply_stimulus(1, 32'hF1F1F1F1, 0, 1, 32'hF2F2F2F2, 0, 1, 0);
        check_output("flush tx level", 32'(tx_level), 32'd0);
        check_output("flush rx level", 32'(rx_level), 32'd0);
        check_output("flush write_data", write_data, 32'h0);
        check_output("flush flags", {30'd0, underrun, overrun}, 32'd0);

        for (int i = 0; i < 40; i++)
            apply_stimulus(i % 3 != 0, 32'hC000 + 32'(i), i % 4 == 1,
                           i % 2 == 0, 32'hD000 + 32'(i), i % 5 == 3, 0, i == 30);

        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) push_tx(32'h700 + 32'(i));
        for (int i = 0; i < 4; i++) push_rx(32'h800 + 32'(i), 0);
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        check_output("async reset tx_level", 32'(tx_level), 32'd0);
        check_output("async reset rx_level", 32'(rx_level), 32'd0);
        check_output("async reset wr_ready", 32'(wr_ready), 32'd1);
        check_output("async reset rd_valid", 32'(rd_valid), 32'd0);
        check_output("async reset write_data", write_data, 32'h0);
        check_output("async reset rd_word", rd_word, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1;
        push_tx(32'h12345678);
        check_output("post-reset head", write_data, 32'h12345678);
        @(posedge clk);
        #1;
        check_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
